// File: rtl/rgbw_out_sched.sv
// rtl/rgbw_out_sched.sv - pops GRB words from a FWFT FIFO and feeds a serial LED encoder
// one bit (or one latch request) per handshake, with optional white-channel extraction.
module rgbw_out_sched #(
  parameter int EXTRACT_W = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_word,
  output logic        fifo_rd,
  input  logic        enc_ready,
  output logic        out_bit_strobe,
  output logic        out_bit_value,
  output logic        out_latch_strobe,
  output logic        busy,
  output logic [15:0] pix_count,
  output logic        err_invalid
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_SEND   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_LATCH  = 3'd4;

  logic [2:0]  state;
  logic [25:0] word_q;     // {valid, stream_reset, G, R, B}
  logic [31:0] shreg;
  logic [4:0]  bit_cnt;
  logic        latch_gap;
  logic        armed;
  logic [7:0]  ch_g, ch_r, ch_b, ch_w;
  logic [31:0] pixel_bits;
  logic        unused_bits;

  assign unused_bits = ^fifo_word[29:24];

  always_comb begin
    ch_g = word_q[23:16];
    ch_r = word_q[15:8];
    ch_b = word_q[7:0];
    ch_w = 8'h00;
    if (EXTRACT_W != 0) begin
      ch_w = (ch_g < ch_r) ? ch_g : ch_r;
      if (ch_b < ch_w) ch_w = ch_b;
    end
    // W is never larger than any channel, so these never wrap; W = 0 gives {G,R,B,0}.
    pixel_bits = {ch_g - ch_w, ch_r - ch_w, ch_b - ch_w, ch_w};
  end

  // armed delays the first pop until the second edge after reset release.
  assign fifo_rd          = (state == S_IDLE) && !fifo_empty && armed;
  assign out_bit_strobe   = (state == S_SEND) && enc_ready;
  assign out_bit_value    = out_bit_strobe && shreg[31];
  assign out_latch_strobe = (state == S_LATCH) && enc_ready;
  assign busy             = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      word_q      <= 26'd0;
      shreg       <= 32'd0;
      bit_cnt     <= 5'd0;
      latch_gap   <= 1'b0;
      armed       <= 1'b0;
      pix_count   <= 16'd0;
      err_invalid <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (fifo_rd) begin
            word_q <= {fifo_word[31:30], fifo_word[23:0]};
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          latch_gap <= 1'b0;
          if (!word_q[25]) begin
            err_invalid <= 1'b1;
            state       <= S_IDLE;
          end else if (word_q[24]) begin
            state <= S_LATCH;
          end else begin
            shreg   <= pixel_bits;
            bit_cnt <= 5'd31;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (enc_ready) begin
            shreg <= {shreg[30:0], 1'b0};
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (bit_cnt == 5'd0) begin
            if (!latch_gap && pix_count != 16'hFFFF) pix_count <= pix_count + 16'd1;
            latch_gap <= 1'b0;
            state     <= S_IDLE;
          end else begin
            bit_cnt <= bit_cnt - 5'd1;
            state   <= S_SEND;
          end
        end
        S_LATCH: begin
          if (enc_ready) begin
            pix_count <= 16'd0;
            bit_cnt   <= 5'd0;
            latch_gap <= 1'b1;
            state     <= S_GAP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgbw_out_sched.sv
// tb/tb_rgbw_out_sched.sv - scoreboard bench for rgbw_out_sched with a FIFO model,
// randomized encoder back-pressure and a word-level reference model.
`timescale 1ns/1ps
module tb_rgbw_out_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty, enc_ready, fifo_rd;
  logic [31:0] fifo_word;
  logic        out_bit_strobe, out_bit_value, out_latch_strobe, busy, err_invalid;
  logic [15:0] pix_count;

  logic        fifo_empty0 = 1'b1;
  logic [31:0] fifo_word0 = 32'h80204060;
  logic        fifo_rd0, out_bit_strobe0, out_bit_value0, out_latch_strobe0, busy0, err_invalid0;
  logic [15:0] pix_count0;

  always #5 clk = ~clk;

  rgbw_out_sched #(.EXTRACT_W(1)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_word(fifo_word), .fifo_rd(fifo_rd),
    .enc_ready(enc_ready), .out_bit_strobe(out_bit_strobe), .out_bit_value(out_bit_value),
    .out_latch_strobe(out_latch_strobe), .busy(busy), .pix_count(pix_count),
    .err_invalid(err_invalid));

  rgbw_out_sched #(.EXTRACT_W(0)) dut0 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty0), .fifo_word(fifo_word0), .fifo_rd(fifo_rd0),
    .enc_ready(1'b1), .out_bit_strobe(out_bit_strobe0), .out_bit_value(out_bit_value0),
    .out_latch_strobe(out_latch_strobe0), .busy(busy0), .pix_count(pix_count0),
    .err_invalid(err_invalid0));

  typedef struct {bit is_latch; bit val; int pix;} ev_t;
  ev_t         exp_q[$];
  logic [31:0] fifo_q[$];
  longint      strobe_cyc[$];
  int          compared = 0, mismatched = 0;
  int          pix_m = 0;
  bit          err_m = 0;
  int          ready_mode = 0;   // 0 random, 1 always ready, 2 stalled
  int          bit_seen = 0;
  longint      cyc = 0, last_strobe_cyc = -100;
  bit          rd_seen = 0;
  bit          dut0_done = 0;

  task automatic check(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: every queued word maps directly to the events it must produce.
  function automatic void push_word(input logic [31:0] w);
    logic [7:0]  g, r, b, m;
    logic [31:0] bits;
    fifo_q.push_back(w);
    if (!w[31]) begin
      err_m = 1'b1;
    end else if (w[30]) begin
      exp_q.push_back('{is_latch: 1'b1, val: 1'b0, pix: pix_m});
      pix_m = 0;
    end else begin
      g = w[23:16]; r = w[15:8]; b = w[7:0];
      m = g;
      if (r < m) m = r;
      if (b < m) m = b;
      bits = {g - m, r - m, b - m, m};
      for (int i = 31; i >= 0; i--)
        exp_q.push_back('{is_latch: 1'b0, val: bits[i], pix: pix_m});
      if (pix_m < 65535) pix_m = pix_m + 1;
    end
  endfunction

  function automatic logic [31:0] rand_word();
    int k;
    k = $urandom_range(0, 99);
    if (k < 85)      rand_word = {2'b10, 6'($urandom), 24'($urandom)};
    else if (k < 95) rand_word = {2'b11, 30'($urandom)};
    else             rand_word = {1'b0, 31'($urandom)};
  endfunction

  // FIFO and encoder-ready drivers, updated just after each active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rd_seen && !rst && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_empty = (fifo_q.size() == 0);
    fifo_word  = fifo_empty ? $urandom : fifo_q[0];
    enc_ready  = (ready_mode == 1) ? 1'b1 :
                 (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 9) < 7);
  end

  // Monitor: all DUT outputs sampled on the falling edge.
  always @(negedge clk) begin
    ev_t e;
    rd_seen = fifo_rd;
    if (fifo_rd) begin
      check("rd_while_empty", fifo_empty, 0);
      check("rd_while_busy", busy, 0);
    end
    if (out_bit_strobe && out_latch_strobe) check("both_strobes", 1, 0);
    if (out_bit_strobe || out_latch_strobe) begin
      check("strobe_without_ready", enc_ready, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", out_latch_strobe, e.is_latch);
        if (!e.is_latch) check("bit_value", out_bit_value, e.val);
        check("pix_at_event", pix_count, e.pix);
      end
      if (out_bit_strobe) begin
        check("strobe_spacing", (cyc - last_strobe_cyc) >= 2, 1);
        last_strobe_cyc = cyc;
        strobe_cyc.push_back(cyc);
        bit_seen++;
      end
    end
  end

  task automatic wait_bits(input int n, input int budget);
    int i;
    for (i = 0; i < budget && bit_seen < n; i++) begin
      @(posedge clk); #2;
    end
    if (bit_seen < n) check("wait_bits_timeout", bit_seen, n);
  endtask

  task automatic wait_drain(input int budget);
    int i;
    bit done;
    done = 0;
    for (i = 0; i < budget && !done; i++) begin
      @(posedge clk); #2;
      done = (exp_q.size() == 0) && (fifo_q.size() == 0) && !busy && !rd_seen;
    end
    if (!done) check("drain_timeout", exp_q.size(), 0);
  endtask

  // EXTRACT_W = 0 instance: one pixel, collected bit by bit.
  initial begin
    logic [31:0] bits0;
    int          n0;
    bit          pop0;
    bits0 = 0; n0 = 0; pop0 = 0;
    @(negedge rst);
    #1 fifo_empty0 = 1'b0;
    for (int i = 0; i < 400 && n0 < 32; i++) begin
      @(negedge clk);
      if (fifo_rd0) pop0 = 1;
      if (out_bit_strobe0) begin
        bits0 = {bits0[30:0], out_bit_value0};
        n0++;
      end
      if (pop0) begin
        @(posedge clk); #1 fifo_empty0 = 1'b1;
        pop0 = 0;
      end
    end
    check("x0_bit_count", n0, 32);
    check("x0_bits", bits0, 32'h20406000);
    repeat (4) @(posedge clk);
    check("x0_pix_count", pix_count0, 1);
    dut0_done = 1;
  end

  initial begin
    int base;
    longint s;
    fifo_empty = 1'b1; fifo_word = 32'h0; enc_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {fifo_rd, out_bit_strobe, out_bit_value, out_latch_strobe, busy, err_invalid}, 0);
    check("reset_pix", pix_count, 0);
    rst = 1'b0;

    // Reference pixel with the encoder always ready.
    ready_mode = 1;
    base = bit_seen;
    push_word(32'h80204060);
    wait_bits(base + 32, 500);
    if (strobe_cyc.size() >= base + 32)
      check("pixel_span", strobe_cyc[base + 31] - strobe_cyc[base], 62);
    wait_drain(200);
    check("pix_after_first", pix_count, 1);

    // Latch, three pixels, latch: latch event sees pix_count 3.
    ready_mode = 0;
    push_word(32'hC0000000);
    for (int i = 0; i < 3; i++) push_word({8'h80, 24'($urandom)});
    push_word(32'hC0000000);
    wait_drain(2000);
    check("pix_after_latch", pix_count, 0);

    push_word(32'h00FFFFFF);
    wait_drain(100);
    check("err_after_invalid", err_invalid, 1);
    check("pix_after_invalid", pix_count, 0);

    // Encoder stalls for 100 clocks mid-pixel.
    ready_mode = 1;
    base = bit_seen;
    push_word({8'h80, 24'($urandom)});
    wait_bits(base + 12, 500);
    ready_mode = 2;
    @(posedge clk); #2;
    s = bit_seen;
    repeat (100) @(posedge clk);
    check("stall_no_strobe", bit_seen, s);
    ready_mode = 0;
    wait_drain(1000);

    // Random stream with random encoder back-pressure and FIFO underruns.
    for (int i = 0; i < 40; i++) begin
      push_word(rand_word());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 150)) @(posedge clk);
    end
    wait_drain(20000);
    check("err_sticky", err_invalid, err_m);
    check("pix_after_random", pix_count, pix_m);

    // Reset at bit 10 of a pixel.
    ready_mode = 1;
    base = bit_seen;
    push_word({8'h80, 24'($urandom)});
    wait_bits(base + 10, 500);
    rst = 1'b1;
    #1;
    check("midreset_outputs", {fifo_rd, out_bit_strobe, out_bit_value, out_latch_strobe, busy, err_invalid}, 0);
    check("midreset_pix", pix_count, 0);
    exp_q.delete();
    pix_m = 0;
    err_m = 0;
    repeat (2) @(posedge clk);
    push_word(32'h80204060);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("pop_too_early", fifo_rd, 0);
    wait_drain(500);
    check("pix_after_reset_pixel", pix_count, 1);
    check("err_after_reset", err_invalid, 0);

    for (int i = 0; i < 1000 && !dut0_done; i++) @(posedge clk);
    check("dut0_finished", dut0_done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/rgbw_out_sched.md
RGBW_OUT_SCHED -- requirements
Module: rgbw_out_sched

Interface
REQ-001 Parameter EXTRACT_W, default 1, meaning: 1 = derive white channel W = min(G,R,B); 0 = W forced to 0 and G/R/B passed unchanged.
REQ-002 clk  input  1  system clock, 96 MHz.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 fifo_empty  input  1  1 = input FIFO holds no word.
REQ-005 fifo_word  input  32  first-word-fall-through FIFO head; bit31 valid, bit30 stream_reset, bits23:16 G, bits15:8 R, bits7:0 B.
REQ-006 fifo_rd  output  1  one-clock pop of the FIFO head.
REQ-007 enc_ready  input  1  1 = serial encoder accepts a strobe this clock.
REQ-008 out_bit_strobe  output  1  one-clock strobe qualifying out_bit_value.
REQ-009 out_bit_value  output  1  bit to transmit; meaningful only with out_bit_strobe.
REQ-010 out_latch_strobe  output  1  one-clock request for an encoder latch (>=50 us low).
REQ-011 busy  output  1  1 whenever state is not IDLE.
REQ-012 pix_count  output  16  pixels sent since last latch.
REQ-013 err_invalid  output  1  sticky; set when a popped word has bit31 = 0.

Function
REQ-014 States SHALL be IDLE, DECODE, SEND, GAP, LATCH.
REQ-015 IDLE: if fifo_empty = 0, the block SHALL assert fifo_rd for exactly one clock, register fifo_word, and enter DECODE; otherwise remain in IDLE.
REQ-016 DECODE, one clock: if bit31 = 0, the block SHALL set err_invalid and return to IDLE.
REQ-017 DECODE: if bit31 = 1 and bit30 = 1, the block SHALL enter LATCH and discard bits23:0.
REQ-018 DECODE: otherwise the block SHALL load a 32-bit shift register with {G-W, R-W, B-W, W} (MSB first), set the bit counter to 31, and enter SEND.
REQ-019 Arithmetic SHALL be 8-bit unsigned; because W <= each channel, no subtraction can underflow.
REQ-020 With EXTRACT_W = 0, the shift register SHALL be loaded with {G, R, B, 8'h00}.
REQ-021 SEND: when enc_ready = 1, the block SHALL pulse out_bit_strobe for one clock with out_bit_value = shreg[31], shift left by 1, and enter GAP; when enc_ready = 0, it SHALL hold with no strobe.
REQ-022 GAP, exactly one clock with no strobes: if the bit counter was 0, the block SHALL increment pix_count and go to IDLE; otherwise it SHALL decrement the counter and return to SEND.
REQ-023 Consequently, strobes SHALL be separated by at least 2 clocks, and one pixel SHALL take at least 64 clocks from SEND entry.
REQ-024 LATCH: when enc_ready = 1, the block SHALL pulse out_latch_strobe for one clock, clear pix_count to 0, and go to GAP with the counter at 0, then to IDLE without incrementing pix_count.
REQ-025 LATCH: when enc_ready = 0, the block SHALL wait.
REQ-026 fifo_rd SHALL never be asserted outside IDLE or when fifo_empty = 1, so at most one word is in flight.
REQ-027 FIFO empty mid-stream SHALL be legal: the block SHALL wait in IDLE with no output and no error.
REQ-028 pix_count SHALL saturate at 16'hFFFF.
REQ-029 out_bit_strobe and out_latch_strobe SHALL never be asserted in the same clock.

Reset
REQ-030 On rst = 1, asynchronously: state = IDLE; fifo_rd, out_bit_strobe, out_bit_value, out_latch_strobe, busy, and err_invalid = 0; pix_count = 0; shift register and counter = 0.
REQ-031 Reset mid-pixel SHALL abandon the pixel with no further strobes; the FIFO word already popped SHALL be lost.
REQ-032 Release SHALL be synchronous to clk edges, and the first pop may occur no earlier than the 2nd clock after deassertion.

Verification
REQ-033 Word 32'h80204060, EXTRACT_W = 1, enc_ready = 1 -> 32 strobes carrying 32'h00204020 MSB first, strobe spacing 2 clocks, pix_count = 1.
REQ-034 Same word with EXTRACT_W = 0 -> bits 32'h20406000, pix_count = 1.
REQ-035 Word 32'hC0000000 after 3 pixels -> one out_latch_strobe, no bit strobes, pix_count 3 -> 0.
REQ-036 Word 32'h00FFFFFF -> err_invalid = 1, no strobes, block returns to IDLE; err_invalid stays 1 until rst.
REQ-037 enc_ready held low for 100 clocks mid-pixel -> no strobes and no lost or duplicated bits; the pixel resumes at the correct bit.
REQ-038 rst asserted at bit 10 of a pixel -> all outputs 0 within the same clock, busy = 0, the next FIFO word is sent completely after release.
